ring_req_inject_arb: RTL
========================

Name: ring_req_inject_arb

Overview:
- Request-ring injection arbiter inside each gpc tile's ring controller.
- Every cycle it decides what occupies the outgoing request slot: a pass-through ring request, or a request from one of the tile's local hardware threads.
- Ring requests addressed to this tile are pulled off the ring and exported locally.
- Tracks one outstanding request per thread; a thread's credit returns when the matching response passes on the response ring.

Parameters:
- NUM_THR, 4, number of local hardware threads (power of 2; thread id width TW = log2(NUM_THR)).
- STARVE_LIMIT, 8, consecutive blocked cycles before StarveAlarm asserts (>=1).

Ports:
- QClk  in  1  tile clock.
- RstQnnnL  in  1  asynchronous active-low reset.
- CoreID  in  8  tile id; also target-match key.
- RingReqInValidQ500H  in  1  incoming ring slot occupied.
- RingReqInRequestorQ500H  in  10  requestor {core, thread}.
- RingReqInOpcodeQ500H  in  t_opcode  opcode from lotr_pkg.
- RingReqInAddressQ500H  in  32  address; [31:24] = target tile.
- RingReqInDataQ500H  in  32  write data.
- RingRspInValidQ500H  in  1  response slot valid (observe only).
- RingRspInRequestorQ500H  in  10  requestor of the response.
- ThrReqValid  in  NUM_THR  per-thread request pending.
- ThrReqOpcode  in  t_opcode x NUM_THR  per-thread opcode.
- ThrReqAddress  in  32 x NUM_THR  per-thread address.
- ThrReqData  in  32 x NUM_THR  per-thread data.
- ThrReqReady  out  NUM_THR  one-hot grant pulse.
- ThrBusy  out  NUM_THR  thread has a request outstanding.
- RingReqOut{Valid,Requestor,Opcode,Address,Data}Q501H  out  1/10/t_opcode/32/32  registered outgoing slot.
- LocalReq{Valid,Requestor,Opcode,Address,Data}Q501H  out  1/10/t_opcode/32/32  registered request consumed by this tile.
- StarveAlarm  out  1  local injection starved.

Behaviour:
- Reset: all outputs 0, ThrBusy 0, RR pointer 0, starve counter 0. Asynchronous assert, synchronous-safe deassert. Reset mid-operation discards in-flight slot and credits.
- Hit is defined as RingReqInValidQ500H && Address[31:24]==CoreID.
- Slot free is defined as !RingReqInValidQ500H || hit.
- Hit: the request is captured into LocalReq*Q501H (valid 1 for exactly one cycle). The ring slot is not forwarded.
- Valid, not hit: all fields are copied to RingReqOut*Q501H. Latency is exactly 1 cycle. Ring traffic always wins; the ring has no backpressure.
- Eligible set is defined as ThrReqValid & ~ThrBusy, using registered ThrBusy.
- Slot free and eligible set non-empty: grant the first eligible thread at or after the RR pointer, wrapping at NUM_THR.
  - Grant thread g drives ThrReqReady[g]=1 combinationally that cycle.
  - Next cycle, RingReqOut*Q501H carries valid 1, Requestor = {CoreID, TW'(g)}, plus thread g's opcode, address and data.
  - ThrBusy[g] is set and the RR pointer becomes g+1 mod NUM_THR.
- Slot free and no grant: RingReqOutValidQ501H = 0. Other RingReqOut fields hold their previous values.
- Requestor field: bits [9:2] are the core id, [TW-1:0] the thread. With NUM_THR=4 that is {CoreID, thr[1:0]}.
- Credit return: when RingRspInValidQ500H && Requestor[9:2]==CoreID, clear ThrBusy[Requestor[TW-1:0]] next cycle. Every request gets exactly one response.
- A response for a non-busy thread is ignored (no underflow, no error).
- Simultaneous clear and grant of the same thread in one cycle is impossible: the grant uses the pre-clear ThrBusy, so the earliest re-grant is the cycle after the clear.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the eligible set is non-empty and the slot is not free.
  - Reset to 0 on any grant, or when the eligible set is empty.
  - StarveAlarm = (counter == STARVE_LIMIT), registered.
- ThrReqValid may drop without a grant (request withdrawn). No state is affected.

Test Plan:
- Reset: hold RstQnnnL=0 with random inputs -> all outputs 0. Release; first grant goes to the lowest valid thread (thread 0 if valid).
- Pass-through: CoreID=1, ring req Address=0x0200_0010, Data=0xDEAD_BEEF, ThrReqValid=4'b0001 -> next cycle RingReqOut carries identical fields, ThrReqReady=0, ThrBusy=0.
- Round-robin on empty ring: CoreID=1, ThrReqValid=4'b0101 -> cycle0 ThrReqReady=0001, RingReqOutRequestor=10'h004 next cycle; cycle1 ThrReqReady=0100, Requestor=10'h006; ThrBusy=0101.
- Local consume plus inject: ring req Address=0x0100_0040, thread 1 valid -> LocalReqValidQ501H=1 with that address, and the same cycle's free slot carries thread 1, Requestor=10'h005.
- Credit: thread 0 granted and kept valid -> no regrant. RingRspIn valid, Requestor=10'h004 at cycle t -> ThrBusy[0]=0 at t+1, grant at t+1. A response with Requestor=10'h204 changes nothing.
- Starvation: STARVE_LIMIT=8, 8 consecutive pass-through slots, thread 3 valid -> StarveAlarm=1 after the 8th blocked cycle. First empty slot grants thread 3; alarm clears the following cycle.

Source files
------------

// File: rtl/lotr_pkg.sv
// ---------------------------------------------------------------------------
// lotr_pkg
// Shared ring-protocol types for the gpc tile ring controllers.
//   t_opcode : request opcode that rides with each ring request.
// ---------------------------------------------------------------------------
package lotr_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_AMO   = 4'd3,
        OP_FENCE = 4'd4
    } t_opcode;

endpackage : lotr_pkg

// File: rtl/ring_req_inject_arb_if.sv
// ---------------------------------------------------------------------------
// ring_req_inject_arb_if
// Groups the bus signals of the request-ring injection arbiter.
//   RingReqIn*Q500H   : incoming request-ring slot (stage 500)
//   RingRspIn*Q500H   : response-ring slot, observed for credit return
//   ThrReq*           : per-thread request offer, ThrReqReady grant pulse
//   ThrBusy           : per-thread outstanding-request flag
//   RingReqOut*Q501H  : registered outgoing request-ring slot (stage 501)
//   LocalReq*Q501H    : registered request consumed by this tile
//   StarveAlarm       : local injection has been blocked too long
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding ring controller / environment view
// ---------------------------------------------------------------------------
interface ring_req_inject_arb_if #(
    parameter int NUM_THR = 4
);

    logic                                     RingReqInValidQ500H;
    logic [9:0]                               RingReqInRequestorQ500H;
    lotr_pkg::t_opcode                        RingReqInOpcodeQ500H;
    logic [31:0]                              RingReqInAddressQ500H;
    logic [31:0]                              RingReqInDataQ500H;

    logic                                     RingRspInValidQ500H;
    logic [9:0]                               RingRspInRequestorQ500H;

    logic [NUM_THR-1:0]                       ThrReqValid;
    lotr_pkg::t_opcode [NUM_THR-1:0]          ThrReqOpcode;
    logic [NUM_THR-1:0][31:0]                 ThrReqAddress;
    logic [NUM_THR-1:0][31:0]                 ThrReqData;
    logic [NUM_THR-1:0]                       ThrReqReady;
    logic [NUM_THR-1:0]                       ThrBusy;

    logic                                     RingReqOutValidQ501H;
    logic [9:0]                               RingReqOutRequestorQ501H;
    lotr_pkg::t_opcode                        RingReqOutOpcodeQ501H;
    logic [31:0]                              RingReqOutAddressQ501H;
    logic [31:0]                              RingReqOutDataQ501H;

    logic                                     LocalReqValidQ501H;
    logic [9:0]                               LocalReqRequestorQ501H;
    lotr_pkg::t_opcode                        LocalReqOpcodeQ501H;
    logic [31:0]                              LocalReqAddressQ501H;
    logic [31:0]                              LocalReqDataQ501H;

    logic                                     StarveAlarm;

    modport slave (
        input  RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
               RingReqInAddressQ500H, RingReqInDataQ500H,
        input  RingRspInValidQ500H, RingRspInRequestorQ500H,
        input  ThrReqValid, ThrReqOpcode, ThrReqAddress, ThrReqData,
        output ThrReqReady, ThrBusy,
        output RingReqOutValidQ501H, RingReqOutRequestorQ501H, RingReqOutOpcodeQ501H,
               RingReqOutAddressQ501H, RingReqOutDataQ501H,
        output LocalReqValidQ501H, LocalReqRequestorQ501H, LocalReqOpcodeQ501H,
               LocalReqAddressQ501H, LocalReqDataQ501H,
        output StarveAlarm
    );

    modport master (
        output RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
               RingReqInAddressQ500H, RingReqInDataQ500H,
        output RingRspInValidQ500H, RingRspInRequestorQ500H,
        output ThrReqValid, ThrReqOpcode, ThrReqAddress, ThrReqData,
        input  ThrReqReady, ThrBusy,
        input  RingReqOutValidQ501H, RingReqOutRequestorQ501H, RingReqOutOpcodeQ501H,
               RingReqOutAddressQ501H, RingReqOutDataQ501H,
        input  LocalReqValidQ501H, LocalReqRequestorQ501H, LocalReqOpcodeQ501H,
               LocalReqAddressQ501H, LocalReqDataQ501H,
        input  StarveAlarm
    );

endinterface : ring_req_inject_arb_if

// File: rtl/ring_req_inject_arb.sv
// ---------------------------------------------------------------------------
// ring_req_inject_arb
// Request-ring injection arbiter of a gpc tile ring controller.
// Each cycle the outgoing request slot is filled with either the
// pass-through ring request or, when the slot is free, a request from one
// of the local hardware threads picked round-robin. Ring requests aimed at
// this tile are pulled off the ring and exported on LocalReq*. Each thread
// may hold one outstanding request; its credit returns when the matching
// response is seen on the response ring.
//
// Ports:
//   QClk     : tile clock
//   RstQnnnL : asynchronous active-low reset
//   CoreID   : tile id, also the target-match key (Address[31:24])
//   bus      : ring_req_inject_arb_if.slave (see interface header)
//
// Parameters:
//   NUM_THR      : local hardware threads, power of 2, 2..4 (thread id
//                  lives in Requestor[TW-1:0] below the core id at [9:2])
//   STARVE_LIMIT : consecutive blocked cycles before StarveAlarm
// ---------------------------------------------------------------------------
module ring_req_inject_arb
    import lotr_pkg::*;
#(
    parameter int NUM_THR      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  QClk,
    input  logic                  RstQnnnL,
    input  logic [7:0]            CoreID,
    ring_req_inject_arb_if.slave  bus
);

    localparam int TW = $clog2(NUM_THR);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    // Saturating increment of the starvation counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        if (cnt >= CW'(STARVE_LIMIT)) begin
            return CW'(STARVE_LIMIT);
        end
        return cnt + CW'(1);
    endfunction

    // Requestor encoding: core id in [9:2], thread id in the low TW bits.
    function automatic logic [9:0] mk_requestor(input logic [7:0]    core,
                                                input logic [TW-1:0] thr);
        logic [9:0] req;
        req         = '0;
        req[9:2]    = core;
        req[TW-1:0] = thr;
        return req;
    endfunction

    // Control state
    logic [NUM_THR-1:0] thr_busy_p1;
    logic [TW-1:0]      rr_ptr_p1;
    logic [CW-1:0]      starve_cnt_p1;
    logic               starve_alarm_p1;

    // Registered outgoing slot
    logic               ring_out_vld_p1;
    logic [9:0]         ring_out_req_p1;
    t_opcode            ring_out_op_p1;
    logic [31:0]        ring_out_addr_p1;
    logic [31:0]        ring_out_data_p1;

    // Registered local consume
    logic               loc_vld_p1;
    logic [9:0]         loc_req_p1;
    t_opcode            loc_op_p1;
    logic [31:0]        loc_addr_p1;
    logic [31:0]        loc_data_p1;

    // Stage 500 decode
    logic               ring_hit_p0;
    logic               slot_free_p0;
    logic [NUM_THR-1:0] eligible_p0;
    logic               gnt_found_p0;
    logic [TW-1:0]      gnt_idx_p0;
    logic [TW-1:0]      cand_p0;
    logic               gnt_vld_p0;
    logic [NUM_THR-1:0] gnt_mask_p0;
    logic               rsp_hit_p0;
    logic [NUM_THR-1:0] clr_mask_p0;
    logic [NUM_THR-1:0] busy_next_p0;
    logic [CW-1:0]      starve_next_p0;

    // ---- stage 500: slot classification, round-robin pick, credits ----
    always_comb begin
        ring_hit_p0  = bus.RingReqInValidQ500H &&
                       (bus.RingReqInAddressQ500H[31:24] == CoreID);
        slot_free_p0 = !bus.RingReqInValidQ500H || ring_hit_p0;
        eligible_p0  = bus.ThrReqValid & ~thr_busy_p1;

        // First eligible thread at or after the pointer; the TW-bit
        // addition wraps naturally at NUM_THR.
        gnt_found_p0 = 1'b0;
        gnt_idx_p0   = '0;
        cand_p0      = '0;
        for (int k = 0; k < NUM_THR; k++) begin
            cand_p0 = rr_ptr_p1 + TW'(k);
            if (!gnt_found_p0 && eligible_p0[cand_p0]) begin
                gnt_found_p0 = 1'b1;
                gnt_idx_p0   = cand_p0;
            end
        end

        gnt_vld_p0  = slot_free_p0 && gnt_found_p0;
        gnt_mask_p0 = gnt_vld_p0 ? (NUM_THR'(1) << gnt_idx_p0) : '0;

        rsp_hit_p0  = bus.RingRspInValidQ500H &&
                      (bus.RingRspInRequestorQ500H[9:2] == CoreID);
        clr_mask_p0 = rsp_hit_p0 ? (NUM_THR'(1) << bus.RingRspInRequestorQ500H[TW-1:0]) : '0;

        // A grant only targets a non-busy thread, so a clear aimed at the
        // same thread is a stray response and the grant must survive it.
        busy_next_p0 = (thr_busy_p1 & ~clr_mask_p0) | gnt_mask_p0;

        starve_next_p0 = starve_cnt_p1;
        if (gnt_vld_p0 || (eligible_p0 == '0)) begin
            starve_next_p0 = '0;
        end else if (!slot_free_p0) begin
            starve_next_p0 = sat_inc(starve_cnt_p1);
        end
    end

    // Grant pulse is forced low while reset is held so all outputs read 0.
    assign bus.ThrReqReady = gnt_mask_p0 & {NUM_THR{RstQnnnL}};

    // ---- stage 501: control registers ----
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            thr_busy_p1     <= '0;
            rr_ptr_p1       <= '0;
            starve_cnt_p1   <= '0;
            starve_alarm_p1 <= 1'b0;
        end else begin
            thr_busy_p1     <= busy_next_p0;
            starve_cnt_p1   <= starve_next_p0;
            starve_alarm_p1 <= (starve_next_p0 == CW'(STARVE_LIMIT));
            if (gnt_vld_p0) begin
                rr_ptr_p1 <= gnt_idx_p0 + TW'(1);
            end
        end
    end

    // ---- stage 501: outgoing ring slot ----
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            ring_out_vld_p1  <= 1'b0;
            ring_out_req_p1  <= '0;
            ring_out_op_p1   <= OP_NOP;
            ring_out_addr_p1 <= '0;
            ring_out_data_p1 <= '0;
        end else if (bus.RingReqInValidQ500H && !ring_hit_p0) begin
            // Ring traffic has priority and no backpressure.
            ring_out_vld_p1  <= 1'b1;
            ring_out_req_p1  <= bus.RingReqInRequestorQ500H;
            ring_out_op_p1   <= bus.RingReqInOpcodeQ500H;
            ring_out_addr_p1 <= bus.RingReqInAddressQ500H;
            ring_out_data_p1 <= bus.RingReqInDataQ500H;
        end else if (gnt_vld_p0) begin
            ring_out_vld_p1  <= 1'b1;
            ring_out_req_p1  <= mk_requestor(CoreID, gnt_idx_p0);
            ring_out_op_p1   <= bus.ThrReqOpcode[gnt_idx_p0];
            ring_out_addr_p1 <= bus.ThrReqAddress[gnt_idx_p0];
            ring_out_data_p1 <= bus.ThrReqData[gnt_idx_p0];
        end else begin
            // Empty slot: payload fields keep their last values.
            ring_out_vld_p1  <= 1'b0;
        end
    end

    // ---- stage 501: local consume ----
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            loc_vld_p1  <= 1'b0;
            loc_req_p1  <= '0;
            loc_op_p1   <= OP_NOP;
            loc_addr_p1 <= '0;
            loc_data_p1 <= '0;
        end else begin
            loc_vld_p1 <= ring_hit_p0;
            if (ring_hit_p0) begin
                loc_req_p1  <= bus.RingReqInRequestorQ500H;
                loc_op_p1   <= bus.RingReqInOpcodeQ500H;
                loc_addr_p1 <= bus.RingReqInAddressQ500H;
                loc_data_p1 <= bus.RingReqInDataQ500H;
            end
        end
    end

    assign bus.ThrBusy                  = thr_busy_p1;
    assign bus.StarveAlarm              = starve_alarm_p1;

    assign bus.RingReqOutValidQ501H     = ring_out_vld_p1;
    assign bus.RingReqOutRequestorQ501H = ring_out_req_p1;
    assign bus.RingReqOutOpcodeQ501H    = ring_out_op_p1;
    assign bus.RingReqOutAddressQ501H   = ring_out_addr_p1;
    assign bus.RingReqOutDataQ501H      = ring_out_data_p1;

    assign bus.LocalReqValidQ501H       = loc_vld_p1;
    assign bus.LocalReqRequestorQ501H   = loc_req_p1;
    assign bus.LocalReqOpcodeQ501H      = loc_op_p1;
    assign bus.LocalReqAddressQ501H     = loc_addr_p1;
    assign bus.LocalReqDataQ501H        = loc_data_p1;

endmodule : ring_req_inject_arb
